// File: rtl/uart_rx_fifo.sv
// Receive FIFO between a UART receiver and the CSR read path: first-word-fall-through
// storage of {err, byte} entries with threshold, overrun and idle-timeout indications.
module uart_rx_fifo #(
    parameter int DEPTH       = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rx_valid_i,
    input  logic [7:0]               rx_data_i,
    input  logic [1:0]               rx_err_i,
    input  logic                     rd_en_i,
    output logic [9:0]               rd_data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o,
    input  logic [$clog2(DEPTH):0]   thresh_i,
    output logic                     thresh_irq_o,
    output logic                     overrun_o,
    input  logic                     ovr_clr_i,
    output logic                     timeout_irq_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int IW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [IW-1:0] TO_L    = IW'(TIMEOUT_CYC);

    logic [9:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          ovr_q, ovr_d;

    logic empty, full, push, pop, drop;

    assign empty = (level_q == '0);
    assign full  = (level_q == DEPTH_L);

    // A pop frees the slot that a same-cycle push into a full FIFO needs.
    assign pop  = rd_en_i && !empty;
    assign push = rx_valid_i && (!full || pop);
    assign drop = rx_valid_i && full && !pop;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        ovr_d   = ovr_q;
        idle_d  = idle_q;

        if (push) wptr_d = wptr_q + AW'(1);
        if (pop)  rptr_d = rptr_q + AW'(1);

        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // A drop in the same cycle as a clear keeps the flag set.
        if (drop)           ovr_d = 1'b1;
        else if (ovr_clr_i) ovr_d = 1'b0;

        if (push || pop || empty) idle_d = '0;
        else if (idle_q != TO_L)  idle_d = idle_q + IW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            idle_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            idle_q  <= idle_d;
            ovr_q   <= ovr_d;
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (push && !reset) mem_q[wptr_q] <= {rx_err_i, rx_data_i};
    end

    assign rd_data_o     = empty ? 10'h000 : mem_q[rptr_q];
    assign empty_o       = empty;
    assign full_o        = full;
    assign level_o       = level_q;
    assign thresh_irq_o  = (thresh_i != '0) && (level_q >= thresh_i);
    assign overrun_o     = ovr_q;
    assign timeout_irq_o = (idle_q == TO_L) && !empty;

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, 16, entry count, power of two, 4..64.
REQ-002 Parameter TIMEOUT_CYC, 64, idle cycles before a receive timeout is flagged, ≥2.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 rx_valid  input  1  one-cycle strobe from the UART receiver: a byte is available.
REQ-006 rx_data  input  8  received byte, qualified by rx_valid.
REQ-007 rx_err  input  2  {frame_err, parity_err} for rx_data, qualified by rx_valid.
REQ-008 rd_en  input  1  pop strobe from the CSR read path, one cycle per pop.
REQ-009 rd_data  output  10  {rx_err, rx_data} of the head entry; first-word-fall-through.
REQ-010 empty  output  1  level == 0.
REQ-011 full  output  1  level == DEPTH.
REQ-012 level  output  log2(DEPTH)+1  current occupancy.
REQ-013 thresh  input  log2(DEPTH)+1  interrupt threshold from CSR.
REQ-014 thresh_irq  output  1  level ≥ thresh, with thresh ≠ 0.
REQ-015 overrun  output  1  sticky: a byte was dropped.
REQ-016 ovr_clr  input  1  clears overrun.
REQ-017 timeout_irq  output  1  data waiting with no traffic for TIMEOUT_CYC cycles.

Function
REQ-018 Storage: DEPTH x 10-bit array; write pointer, read pointer and level are registers.
REQ-019 Push:
- Occurs when rx_valid=1 and (full=0, or a pop occurs in the same cycle).
- Writes {rx_err, rx_data} at wptr.
- wptr increments modulo DEPTH.
REQ-020 Pop:
- Occurs when rd_en=1 and empty=0.
- rptr increments modulo DEPTH.
- rd_en while empty is ignored; no state change.
REQ-021 rd_data equals mem[rptr] combinationally when empty=0, and 0 when empty=1.
REQ-022 After a push into an empty FIFO, rd_data and empty=0 are valid the following cycle; there is no same-cycle bypass.
REQ-023 level update rule:
- push only: +1.
- pop only: -1.
- both, or neither: unchanged.
- level never exceeds DEPTH and never underflows.
REQ-024 Simultaneous push and pop when full: both accepted, level stays DEPTH, overrun not set.
REQ-025 Simultaneous push and pop when empty: push accepted, pop ignored, level becomes 1.
REQ-026 rx_valid=1 while full with no pop:
- Byte dropped; no memory or pointer change.
- overrun set the next cycle.
REQ-027 ovr_clr=1 clears overrun next cycle; if a drop occurs in the same cycle, set wins.
REQ-028 full, empty and thresh_irq are combinational from the level register.
REQ-029 Pointer wrap from DEPTH-1 to 0 is seamless; ordering is strictly FIFO.
REQ-030 Idle counter:
- Counts clock cycles while empty=0 and neither push nor pop occurs.
- Cleared on any push, on any pop, and while empty=1.
- Saturates at TIMEOUT_CYC.
REQ-031 timeout_irq is asserted while the idle counter equals TIMEOUT_CYC and empty=0; it deasserts the cycle after the next push or pop.

Reset
REQ-032 Assertion of reset immediately clears wptr, rptr, level, the idle counter and overrun, independent of clk.
REQ-033 During reset:
- empty=1, full=0, level=0, rd_data=0, thresh_irq=0, overrun=0, timeout_irq=0.
- Memory contents need not be cleared.
REQ-034 reset mid-operation discards all stored bytes; rx_valid and rd_en asserted while reset is high are ignored.
REQ-035 First push is accepted on the first rising clk edge after reset deasserts.

Verification
REQ-036 After reset: push 0x41, 0x42, 0x43 with rx_err=0 on consecutive cycles -> level=3; then pop 3 times -> rd_data sequence 0x041, 0x042, 0x043; then empty=1.
REQ-037 Push 17 bytes (0x00..0x10) with no pops ->
- full=1 after the 16th push.
- 17th byte dropped; overrun=1.
- Popping 16 times returns 0x00..0x0F.
- ovr_clr -> overrun=0.
REQ-038 With full=1, assert rx_valid (0xAA) and rd_en in the same cycle -> level stays 16, overrun=0, 0xAA is returned as the 16th subsequent pop.
REQ-039 thresh=4, push 4 bytes -> thresh_irq=1 the cycle after the 4th push; one pop -> thresh_irq=0.
REQ-040 Push one byte with rx_err=2'b10, then idle -> timeout_irq=1 after 64 idle cycles, rd_data=0x2xx (frame_err set); pop -> timeout_irq=0 and empty=1.
REQ-041 Reset asserted with level=5 mid-stream, between clock edges -> empty=1 and level=0 immediately; after release, the next push is read back first.
